// File: rtl/run_step_controller_pkg.sv
// Shared processor constants: run/step FSM state
// encodings and halt cause codes.
package run_step_controller_pkg;

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_DONE = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    C_NONE  = 2'b00,
    C_BREAK = 2'b01,
    C_STOP  = 2'b10,
    C_ERROR = 2'b11
  } cause_t;

endpackage

// File: rtl/run_step_controller_button_debouncer.sv
// Step button: 2-flop synchronizer, stable-sample
// debounce and rising-edge pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      rise <= 1'b0;
      // cnt tracks how many samples in a row disagreed
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= s2;
        rise  <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/run_step_controller.sv
// Run / single-step / breakpoint controller gating
// the processor pipeline clock enable.
module run_step_controller
  import run_step_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             bp_enable,
  input  logic [7:0]       bp_addr,
  input  logic [7:0]       program_counter,
  input  logic             instr_stop,
  input  logic             error_flag,
  output logic             proc_enable,
  output logic [1:0]       state_out,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] step_count
);

  state_t state;
  cause_t cause;
  logic   first_run;
  logic   run_q;
  logic   run_low_seen;
  logic   step_level;
  logic   step_req;
  logic   bp_match;
  logic   bp_hit;
  logic   stop_now;
  logic   run_rise;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clock(clock),
    .reset(reset),
    .btn  (step_btn),
    .level(step_level),
    .rise (step_req)
  );

  // run_low_seen blocks a switch left high across reset
  always_comb begin
    bp_match = bp_enable && (program_counter == bp_addr);
    bp_hit   = bp_match && !first_run;
    stop_now = error_flag | instr_stop | bp_hit | ~run_sw;
    run_rise = run_sw & ~run_q & run_low_seen;
    proc_enable = (state == S_STEP) ||
                  ((state == S_RUN) && !stop_now);
  end

  assign state_out  = state;
  assign halt_cause = cause;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_HALT;
      cause        <= C_NONE;
      step_count   <= '0;
      first_run    <= 1'b0;
      run_q        <= 1'b0;
      run_low_seen <= 1'b0;
    end else begin
      run_q        <= run_sw;
      run_low_seen <= run_low_seen | ~run_sw;
      first_run    <= 1'b0;
      if (proc_enable)
        step_count <= step_count + CNT_W'(1);
      unique case (state)
        S_HALT: begin
          if (step_req) begin
            state <= S_STEP;
          end else if (run_rise) begin
            state     <= S_RUN;
            cause     <= C_NONE;
            first_run <= 1'b1;
          end
        end
        S_STEP: begin
          if (error_flag) begin
            state <= S_DONE;
            cause <= C_ERROR;
          end else if (instr_stop) begin
            state <= S_DONE;
            cause <= C_STOP;
          end else begin
            state <= S_HALT;
            cause <= bp_match ? C_BREAK : C_NONE;
          end
        end
        S_RUN: begin
          if (error_flag) begin
            state <= S_DONE;
            cause <= C_ERROR;
          end else if (instr_stop) begin
            state <= S_DONE;
            cause <= C_STOP;
          end else if (bp_hit) begin
            state <= S_HALT;
            cause <= C_BREAK;
          end else if (!run_sw) begin
            state <= S_HALT;
            cause <= C_NONE;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  logic unused_level;
  assign unused_level = step_level;

endmodule

// File: doc/run_step_controller.md
RUN_STEP_CONTROLLER -- requirements
Module: run_step_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL be the number of consecutive stable samples required to accept a step_btn level change.
REQ-002 Parameter CNT_W, default 16, SHALL be the width of step_count.
REQ-003 clock  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be synchronous, active-low.
REQ-005 run_sw  in  1  SHALL be the run/halt slide switch (level).
REQ-006 step_btn  in  1  SHALL be the raw, asynchronous single-step pushbutton.
REQ-007 bp_enable  in  1  SHALL arm the PC breakpoint.
REQ-008 bp_addr  in  8  SHALL be the breakpoint program-counter value.
REQ-009 program_counter  in  8  SHALL be the processor's current PC.
REQ-010 instr_stop  in  1  SHALL be the processor's end-of-program signal.
REQ-011 error_flag  in  1  SHALL be the processor's error flag.
REQ-012 proc_enable  out  1  SHALL be the clock enable to the processor pipeline.
REQ-013 state_out  out  2  SHALL be the current FSM state encoding.
REQ-014 halt_cause  out  2  SHALL be the reason for the last stop.
REQ-015 step_count  out  CNT_W  SHALL be the count of enabled processor cycles.

Function
REQ-016 The FSM SHALL have states HALT=00, RUN=01, STEP=10, DONE=11.
REQ-017 halt_cause codes SHALL be MANUAL/NONE=00, BREAK=01, STOP=10, ERROR=11.
REQ-018 step_btn SHALL pass through a 2-flop synchronizer; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive equal synchronized samples. A debounced 0->1 transition SHALL produce a one-cycle step_req.
REQ-019 run_rise SHALL be a one-cycle pulse on a registered 0->1 transition of run_sw.
REQ-020 HALT: proc_enable=0. step_req SHALL move the FSM to STEP. Otherwise, run_rise SHALL move it to RUN. If both occur in the same cycle, step_req SHALL win.
REQ-021 STEP: proc_enable=1 for exactly one cycle. The FSM SHALL then move to HALT with halt_cause=BREAK if the breakpoint matches, else MANUAL.
REQ-022 RUN: stop_now = error_flag | instr_stop | bp_hit | ~run_sw. bp_hit = bp_enable & (program_counter==bp_addr) & ~first_run_cycle.
REQ-023 RUN: proc_enable = ~stop_now (combinational gate), so the instruction at bp_addr is not executed.
REQ-024 RUN exit priority SHALL be: error_flag -> DONE/ERROR; instr_stop -> DONE/STOP; bp_hit -> HALT/BREAK; ~run_sw -> HALT/MANUAL.
REQ-025 first_run_cycle SHALL be 1 only on the first cycle after entering RUN, allowing resume from a breakpoint.
REQ-026 DONE: proc_enable=0. DONE SHALL be sticky; only reset SHALL leave it. step_req and run_rise SHALL be ignored.
REQ-027 step_req SHALL be ignored in RUN, STEP and DONE (not queued).
REQ-028 step_count SHALL increment by 1 on every cycle with proc_enable=1 and SHALL wrap from all-ones to 0.
REQ-029 error_flag or instr_stop asserted during STEP SHALL take the FSM to DONE with the corresponding cause, using the REQ-024 priority.

Reset
REQ-030 While reset=0 at a clock edge: state=HALT, proc_enable=0, halt_cause=00, step_count=0, synchronizer/debounce state=0, debounced level=0, run_sw history=0.
REQ-031 Reset mid-RUN or mid-STEP SHALL drop proc_enable in the cycle after the sampling edge. No pending step_req or run_rise SHALL survive reset.
REQ-032 After reset, run_sw already high SHALL NOT start RUN until it is cycled low then high.

Structure
REQ-033 The state encodings and halt_cause codes SHALL live in the shared processor constants package.
REQ-034 The synchronizer plus debounce plus edge detect SHALL be one sub-module, button_debouncer, parameterized by DEBOUNCE_CYCLES.
REQ-035 All remaining logic SHALL be flat in run_step_controller.

Verification (DEBOUNCE_CYCLES=4)
REQ-036 Reset, then step_btn high for 10 cycles -> exactly one proc_enable pulse; step_count=1; state HALT; cause 00.
REQ-037 step_btn glitches high for 2 cycles three times -> no proc_enable pulse; step_count=0.
REQ-038 bp_enable=1, bp_addr=8'h05, run_sw 0->1, PC reaches 05 -> proc_enable=0 in that same cycle; state HALT; cause 01. Then run_sw 1->0->1 -> exactly one enabled cycle at PC 05, execution continues.
REQ-039 In RUN, error_flag and instr_stop asserted together -> DONE, cause 11. Subsequent step_btn and run_sw toggles -> proc_enable stays 0 until reset.
REQ-040 Preload step_count=16'hFFFE via the run sequence, then 3 enabled cycles -> step_count=16'h0001.
REQ-041 reset=0 for one cycle mid-RUN with run_sw held high -> state HALT, outputs at reset values; no RUN until run_sw is toggled.
